// File: rtl/adder32_share_arb_if.sv
// adder32_share_arb_if: request and response channels of the shared adder arbiter
interface adder32_share_arb_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] req_sub;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic res_valid;
  logic res_ready;
  logic [31:0] res_sum;
  logic res_co;
  logic res_ovf;
  logic [ID_W-1:0] res_id;
  modport master (
    output req_valid, req_sub, req_a, req_b, res_ready,
    input req_ready, res_valid, res_sum, res_co, res_ovf, res_id
  );
  modport slave (
    input req_valid, req_sub, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_co, res_ovf, res_id
  );
endinterface

// File: rtl/adder32_share_arb.sv
// adder32_share_arb: round-robin shared 32-bit ripple-carry adder with multicycle settle and tagged response
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  logic [32:0] w_c;
  assign w_c[0] = ci;
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign co = w_c[32];
endmodule

module adder32_share_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  adder32_share_arb_if.slave bus,
  output logic busy
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  state_t r_state, w_next;
  logic [ID_W-1:0] r_ptr, r_id, w_gnt, r_res_id;
  logic [CW-1:0] r_cnt;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0] w_rot;
  logic [31:0] r_a, r_b, w_s, w_sel_a, w_sel_b, r_sum;
  logic r_ci, w_co, w_sel_sub, w_found, w_accept, w_done;
  logic r_valid, r_co, r_ovf;
  // rotate so bit 0 is the requester at rr_ptr; lowest set bit wins
  assign w_dbl = {bus.req_valid, bus.req_valid} >> r_ptr;
  assign w_rot = w_dbl[NREQ-1:0];
  always_comb begin
    w_found = 1'b0;
    w_gnt = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    w_sel_sub = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--)
      if (w_rot[j]) begin
        w_found = 1'b1;
        w_gnt = ID_W'((int'(r_ptr) + j) % NREQ);
      end
    for (int j = 0; j < NREQ; j++)
      if (w_found && int'(w_gnt) == j) begin
        w_sel_a = bus.req_a[32*j +: 32];
        w_sel_b = bus.req_b[32*j +: 32];
        w_sel_sub = bus.req_sub[j];
      end
  end
  assign w_accept = !rst && r_state == IDLE && w_found;
  assign bus.req_ready = w_accept ? NREQ'(1) << w_gnt : '0;
  adder32 u_add (.a(r_a), .b(r_b), .ci(r_ci), .s(w_s), .co(w_co));
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_done = r_state == EVAL && r_cnt == '0;
    w_next = r_state == IDLE ? (w_found ? EVAL : IDLE) :
             r_state == EVAL ? (w_done ? RESP : EVAL) :
             (bus.res_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_ci <= 1'b0;
      r_id <= '0;
      r_valid <= 1'b0;
      r_sum <= '0;
      r_co <= 1'b0;
      r_ovf <= 1'b0;
      r_res_id <= '0;
    end else begin
      if (w_accept) begin
        r_a <= w_sel_a;
        r_b <= w_sel_sub ? ~w_sel_b : w_sel_b;
        r_ci <= w_sel_sub;
        r_id <= w_gnt;
        r_ptr <= ID_W'((int'(w_gnt) + 1) % NREQ);
        r_cnt <= CW'(SETTLE_CYCLES - 1);
      end
      if (r_state == EVAL && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_done) begin
        r_sum <= w_s;
        r_co <= w_co;
        r_ovf <= (r_a[31] == r_b[31]) && (w_s[31] != r_a[31]);
        r_res_id <= r_id;
        r_valid <= 1'b1;
      end
      if (r_state == RESP && bus.res_ready) r_valid <= 1'b0;
    end
  assign bus.res_valid = r_valid;
  assign bus.res_sum = r_sum;
  assign bus.res_co = r_co;
  assign bus.res_ovf = r_ovf;
  assign bus.res_id = r_res_id;
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_adder32_share_arb.sv
// tb_adder32_share_arb: directed table, hand sequences and randomized checks against an arithmetic model
module tb_adder32_share_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int n_tests = 0;
  int n_fail = 0;
  int m_ptr = 0;
  logic [31:0] opa [4];
  logic [31:0] opb [4];
  logic [3:0] ts;
  localparam longint MAXS = 2147483647;
  localparam longint MINS = -MAXS - 1;
  typedef struct {
    int id;
    logic [31:0] a, b;
    logic sub;
    logic [31:0] sum;
    logic co, ovf;
  } vec_t;
  vec_t vt [5];
  adder32_share_arb_if #(.NREQ(4), .ID_W(2)) bus ();
  adder32_share_arb #(.NREQ(4), .ID_W(2), .SETTLE_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint sr;
    logic [32:0] u;
    logic co, ovf;
    sr = sub ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
    u = {1'b0, a} + {1'b0, b};
    co = sub ? (a >= b) : u[32];
    ovf = sr > MAXS || sr < MINS;
    return {co, ovf, sub ? a - b : a + b};
  endfunction
  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 9);
    return r == 0 ? 32'h0 : r == 1 ? 32'hFFFF_FFFF : r == 2 ? 32'h7FFF_FFFF : r == 3 ? 32'h8000_0000 :
           r == 4 ? 32'h1 : $urandom();
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[32*i +: 32] = opa[i];
      bus.req_b[32*i +: 32] = opb[i];
    end
    bus.req_sub = ts;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0;
  endtask
  task automatic wait_valid(input string nm);
    int t;
    t = 0;
    while (!bus.res_valid && t < 40) begin @(posedge clk); #1; t++; end
    if (t >= 40) chk({nm, " timeout"}, 64'(0), 64'(1));
  endtask
  // starts and ends one tick after a rising edge with the DUT idle
  task automatic run(input logic [3:0] mask, input int stall, input string nm, output logic [33:0] got);
    int g, t, mi;
    logic [33:0] e;
    mi = int'(mask);
    g = 0;
    for (int k = 3; k >= 0; k--) if (((mi >> ((m_ptr + k) % 4)) & 1) != 0) g = (m_ptr + k) % 4;
    e = model(opa[g], opb[g], ts[g]);
    drive_ops();
    bus.req_valid = mask;
    bus.res_ready = stall == 0;
    #1;
    chk({nm, " grant"}, 64'(bus.req_ready), 64'(1) << g);
    @(posedge clk); #1;
    bus.req_valid = '0;
    m_ptr = (g + 1) % 4;
    t = 1;
    while (!bus.res_valid && t < 40) begin @(posedge clk); #1; t++; end
    chk({nm, " latency"}, 64'(t), 64'(3));
    repeat (stall) begin @(posedge clk); #1; end
    got = {bus.res_co, bus.res_ovf, bus.res_sum};
    chk({nm, " result"}, 64'(got), 64'(e));
    chk({nm, " id"}, 64'(bus.res_id), 64'(g));
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " idle"}, 64'({bus.res_valid, busy}), 64'(0));
  endtask
  initial begin
    logic [33:0] got, snap, e;
    logic [1:0] sid;
    int gr[$], gc[$], rid[$];
    int pulses;
    vt[0] = '{0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
    vt[1] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[2] = '{2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[3] = '{1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[4] = '{1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin opa[i] = '0; opb[i] = '0; end
    ts = '0;
    drive_ops();
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 64'(bus.req_ready), 64'(0));
    chk("reset outputs", 64'({bus.res_valid, busy, bus.res_sum, bus.res_co, bus.res_ovf, bus.res_id}), 64'(0));
    rst = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      opa[vt[i].id] = vt[i].a;
      opb[vt[i].id] = vt[i].b;
      ts[vt[i].id] = vt[i].sub;
      run(4'(1 << vt[i].id), 0, $sformatf("vec%0d", i), got);
      chk($sformatf("vec%0d table", i), 64'(got), 64'({vt[i].co, vt[i].ovf, vt[i].sum}));
    end
    do_reset();
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 22; c++) begin
      #1;
      for (int i = 0; i < 4; i++) if (bus.req_ready[i]) begin gr.push_back(i); gc.push_back(c); end
      if (bus.res_valid) rid.push_back(int'(bus.res_id));
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    chk("rr grant count", 64'(gr.size() >= 5), 64'(1));
    for (int k = 0; k < 5 && k < gr.size(); k++) chk($sformatf("rr grant%0d", k), 64'(gr[k]), 64'(k % 4));
    for (int k = 1; k < 5 && k < gc.size(); k++) chk($sformatf("rr spacing%0d", k), 64'(gc[k] - gc[k-1]), 64'(4));
    chk("rr resp count", 64'(rid.size() >= 4), 64'(1));
    for (int k = 0; k < 4 && k < rid.size(); k++) chk($sformatf("rr res_id%0d", k), 64'(rid[k]), 64'(k));
    for (int t = 0; t < 20 && busy; t++) begin @(posedge clk); #1; end
    do_reset();
    opa[0] = 32'h0000_1234; opb[0] = 32'h0000_1111; ts = '0;
    drive_ops();
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b0;
    #1;
    chk("bp grant0", 64'(bus.req_ready), 64'(1));
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_valid("bp first");
    snap = {bus.res_co, bus.res_ovf, bus.res_sum};
    sid = bus.res_id;
    chk("bp first result", 64'({snap, sid}), 64'({model(opa[0], opb[0], 1'b0), 2'd0}));
    opa[3] = 32'hDEAD_0000; opb[3] = 32'h0000_BEEF; ts[3] = 1'b1;
    drive_ops();
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d", c), 64'({busy, bus.res_valid, bus.req_ready, bus.res_co, bus.res_ovf, bus.res_sum, bus.res_id}),
          64'({1'b1, 1'b1, 4'b0000, snap, sid}));
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp grant3", 64'({bus.res_valid, bus.req_ready}), 64'({1'b0, 4'b1000}));
    @(posedge clk); #1;
    bus.req_valid = '0;
    m_ptr = 0;
    wait_valid("bp second");
    e = model(opa[3], opb[3], 1'b1);
    chk("bp second result", 64'({bus.res_co, bus.res_ovf, bus.res_sum, bus.res_id}), 64'({e, 2'd3}));
    @(posedge clk); #1;
    opa[2] = 32'h0000_0010; opb[2] = 32'h0000_0020; ts = '0;
    drive_ops();
    bus.req_valid = 4'b0100;
    #1;
    chk("rst grant2", 64'(bus.req_ready), 64'(4));
    @(posedge clk); #1;
    bus.req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst mid outputs", 64'({bus.res_valid, busy, bus.res_sum, bus.res_co, bus.res_ovf, bus.res_id}), 64'(0));
    rst = 1'b0;
    m_ptr = 0;
    pulses = 0;
    repeat (6) begin @(posedge clk); #1; pulses += int'(bus.res_valid); end
    chk("rst no pulse", 64'(pulses), 64'(0));
    opa[1] = 32'h0000_0100; opb[1] = 32'h0000_0001; opa[3] = 32'h5; opb[3] = 32'h5;
    run(4'b1010, 0, "post rst", got);
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 4; j++) begin opa[j] = pick(); opb[j] = pick(); end
      ts = 4'($urandom());
      run(4'($urandom_range(1, 15)), $urandom_range(0, 3), $sformatf("rnd%0d", n), got);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder32_share_arb.md
Name: adder32_share_arb

Overview:
- Shares one 32-bit ripple-carry adder datapath (adder32 instance, s/co/a/b/ci) between NREQ requesters.
- Round-robin arbiter plus an FSM:
  - accept one add/sub request;
  - latch its operands;
  - hold them stable for SETTLE_CYCLES so the ripple carry settles (multicycle path);
  - register sum/carry/overflow;
  - present the result on a valid/ready response channel tagged with the requester id.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester id; must satisfy 2**ID_W >= NREQ
- SETTLE_CYCLES, 2, cycles operands are held at the adder before result capture (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_a  input  32*NREQ  operand A, requester i at bits [32*i+31:32*i]
- req_b  input  32*NREQ  operand B, same packing
- req_sub  input  NREQ  1 = A-B, 0 = A+B
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- res_sum  output  32  sum/difference
- res_co  output  1  adder carry-out; for sub, 1 = no borrow
- res_ovf  output  1  signed overflow
- res_id  output  ID_W  index of requester that owns the result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock domain, clk; reset rst is synchronous and active-high.
- Reset state (next edge with rst=1):
  - state=IDLE, rr_ptr=0, settle counter=0;
  - res_valid=0, res_sum=0, res_co=0, res_ovf=0, res_id=0, busy=0;
  - req_ready=0 combinationally while rst=1.
- Reset mid-operation aborts the in-flight request; no result is produced for it.
- States: IDLE, EVAL, RESP.
- IDLE:
  - If any req_valid, grant the first set bit searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - req_ready[grant]=1 combinationally in that cycle only.
  - At the edge: latch op_a=req_a[grant]; op_b=req_sub ? ~req_b[grant] : req_b[grant]; op_ci=req_sub[grant]; op_id=grant.
  - At the same edge: rr_ptr <= (grant+1) mod NREQ; counter <= SETTLE_CYCLES-1; state -> EVAL.
  - No req_valid: remain in IDLE, all req_ready=0, rr_ptr unchanged.
- EVAL:
  - Adder inputs driven only from the op_* registers, stable for the whole state.
  - If counter != 0, decrement.
  - If counter == 0: at the edge capture res_sum=s, res_co=co, res_ovf=(op_a[31]==op_b[31]) & (s[31]!=op_a[31]), res_id=op_id; res_valid<=1; state -> RESP.
- RESP:
  - Outputs held stable while res_valid=1 and res_ready=0 (backpressure, unbounded).
  - When res_ready=1: res_valid<=0 at the edge, state -> IDLE.
  - No new request is accepted in RESP.
- Latency: request accepted in cycle t; res_valid first high in cycle t+SETTLE_CYCLES+1. Default: accept at 0, result at 3.
- Minimum issue interval: SETTLE_CYCLES+2 cycles with res_ready held high.
- Requesters hold req_valid and operands until their req_ready is seen. Deasserting beforehand is legal, and the request is simply not granted.
- req_ready is never asserted outside IDLE. At most one req_ready bit is high in any cycle.
- Arithmetic is modulo 2^32; res_co and res_ovf are reported, never saturated.
- busy = (state != IDLE).

Test Plan:
1. Reset, then single add: requester 0, A=0x0000_0005, B=0x0000_0003, add -> req_ready[0] in cycle 0; res_valid in cycle 3; sum=0x0000_0008, co=0, ovf=0, id=0.
2. Carry/overflow: requester 2, A=0xFFFF_FFFF, B=0x0000_0001, add -> sum=0, co=1, ovf=0. Then A=0x7FFF_FFFF, B=1 -> sum=0x8000_0000, co=0, ovf=1.
3. Subtract: requester 1, A=3, B=5, sub -> sum=0xFFFF_FFFE, co=0 (borrow), ovf=0. Then A=0x8000_0000, B=1, sub -> sum=0x7FFF_FFFF, co=1, ovf=1.
4. Round robin: all four req_valid held continuously, res_ready=1 -> grant order 0,1,2,3,0; grants spaced 4 cycles apart (SETTLE_CYCLES=2); res_id follows the same order.
5. Backpressure: res_ready=0 for 10 cycles after res_valid -> res_* stable and busy=1 throughout. Meanwhile req_valid[3]=1 with req_ready[3]=0. Raise res_ready -> IDLE, then requester 3 granted the next cycle.
6. Reset mid-EVAL: assert rst one cycle after accept -> all outputs zero at the next edge, no res_valid pulse, rr_ptr=0; the next request from requester 1 completes normally.
